// File: rtl/trace_chain_checker_pkg.sv
// Shared layout, state/fail encodings and the fetch + tiny86 single-step helpers
// used by the trace chain checker.
package trace_chain_checker_pkg;

    localparam int LAYOUT_STEP_W   = 560;
    localparam int LAYOUT_REG_W    = 32;
    localparam int LAYOUT_NUM_REGS = 10;
    localparam int INSN_BYTES      = (LAYOUT_STEP_W - LAYOUT_NUM_REGS * LAYOUT_REG_W) / 8;

    localparam logic [31:0] EFLAGS_MASK_DEF = 32'h0000_08D5;

    // Register slots, also the mismatch mask bit order
    localparam logic [3:0] R_EAX    = 4'd0;
    localparam logic [3:0] R_EBX    = 4'd1;
    localparam logic [3:0] R_ECX    = 4'd2;
    localparam logic [3:0] R_EDX    = 4'd3;
    localparam logic [3:0] R_ESI    = 4'd4;
    localparam logic [3:0] R_EDI    = 4'd5;
    localparam logic [3:0] R_ESP    = 4'd6;
    localparam logic [3:0] R_EBP    = 4'd7;
    localparam logic [3:0] R_EIP    = 4'd8;
    localparam logic [3:0] R_EFLAGS = 4'd9;

    localparam int F_PF = 2;
    localparam int F_AF = 4;
    localparam int F_ZF = 6;
    localparam int F_SF = 7;
    localparam int F_OF = 11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_OVERFLOW = 2'd2;

    typedef logic [LAYOUT_NUM_REGS-1:0][LAYOUT_REG_W-1:0] regs_t;

    // Register file in the low bits, instruction window (byte 0 at eip) above it
    typedef struct packed {
        logic [INSN_BYTES-1:0][7:0] insn;
        regs_t                      regs;
    } step_t;

    function automatic step_t fetch(input logic [LAYOUT_STEP_W-1:0] raw);
        return step_t'(raw);
    endfunction

    function automatic regs_t fetch_regs(input logic [LAYOUT_STEP_W-1:0] raw);
        step_t s;
        s = step_t'(raw);
        return s.regs;
    endfunction

    // x86 register encoding (eax,ecx,edx,ebx,esp,ebp,esi,edi) to mask slot
    function automatic logic [3:0] gpr_slot(input logic [2:0] enc);
        case (enc)
            3'd0:    return R_EAX;
            3'd1:    return R_ECX;
            3'd2:    return R_EDX;
            3'd3:    return R_EBX;
            3'd4:    return R_ESP;
            3'd5:    return R_EBP;
            3'd6:    return R_ESI;
            default: return R_EDI;
        endcase
    endfunction

    // inc r32 / dec r32 / mov r32,imm32; any other opcode retires as a 1-byte nop
    function automatic regs_t tiny86(input step_t s);
        regs_t                   r;
        logic [7:0]              op;
        logic [3:0]              slot;
        logic [LAYOUT_REG_W-1:0] a;
        logic [LAYOUT_REG_W-1:0] res;
        logic                    is_dec;
        r      = s.regs;
        op     = s.insn[0];
        slot   = gpr_slot(op[2:0]);
        a      = s.regs[slot];
        is_dec = op[3];
        res    = is_dec ? a - 32'd1 : a + 32'd1;
        r[R_EIP] = s.regs[R_EIP] + 32'd1;
        case (op[7:3])
            5'b01000, 5'b01001: begin
                r[slot] = res;
                r[R_EFLAGS][F_OF] = is_dec ? (a == 32'h8000_0000) : (a == 32'h7FFF_FFFF);
                r[R_EFLAGS][F_SF] = res[31];
                r[R_EFLAGS][F_ZF] = (res == '0);
                r[R_EFLAGS][F_AF] = is_dec ? (a[3:0] == 4'h0) : (a[3:0] == 4'hF);
                r[R_EFLAGS][F_PF] = ~^res[7:0];
            end
            5'b10111: begin
                r[slot]  = s.insn[4:1];
                r[R_EIP] = s.regs[R_EIP] + 32'd5;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/trace_chain_checker_step_compare.sv
// Predicts the next architectural state from the previous step and flags every
// register of the incoming step that disagrees with the prediction.
module trace_chain_checker_step_compare
    import trace_chain_checker_pkg::*;
#(
    parameter logic [31:0] EFLAGS_MASK = EFLAGS_MASK_DEF
) (
    input  logic [LAYOUT_STEP_W-1:0]   step,
    input  logic [LAYOUT_STEP_W-1:0]   prev,
    output logic [LAYOUT_NUM_REGS-1:0] mismatch
);

    regs_t predicted;
    regs_t reported;

    assign predicted = tiny86(fetch(prev));
    assign reported  = fetch_regs(step);

    for (genvar i = 0; i < LAYOUT_NUM_REGS; i++) begin : g_reg
        if (i == int'(R_EFLAGS)) begin : g_flags
            assign mismatch[i] = |((predicted[i] ^ reported[i]) & EFLAGS_MASK);
        end else begin : g_full
            assign mismatch[i] = (predicted[i] != reported[i]);
        end
    end

endmodule

// File: rtl/trace_chain_checker.sv
// Streams trace steps, checks each against the single-step prediction of its
// predecessor, and latches the verdict of the first failure.
module trace_chain_checker
    import trace_chain_checker_pkg::*;
#(
    parameter int                STEP_W      = LAYOUT_STEP_W,
    parameter int                REG_W       = LAYOUT_REG_W,
    parameter int                NUM_REGS    = LAYOUT_NUM_REGS,
    parameter int                CNT_W       = 32,
    parameter logic [REG_W-1:0]  EFLAGS_MASK = EFLAGS_MASK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [STEP_W-1:0]   s_step,
    input  logic                s_last,
    output logic                done,
    output logic                ok,
    output logic [1:0]          fail_code,
    output logic [CNT_W-1:0]    fail_index,
    output logic [NUM_REGS-1:0] mismatch_mask,
    output logic [CNT_W-1:0]    step_count
);

    logic [1:0]          state;
    logic [STEP_W-1:0]   step_q;
    logic [CNT_W-1:0]    count;
    logic [NUM_REGS-1:0] mm;
    logic                accept;
    logic                at_max;

    assign s_ready    = (state == ST_IDLE || state == ST_RUN) && !clear;
    assign accept     = s_valid && s_ready;
    assign at_max     = &count;
    assign done       = (state == ST_DONE) || (state == ST_FAIL);
    assign ok         = (state == ST_DONE);
    assign step_count = count;

    trace_chain_checker_step_compare #(
        .EFLAGS_MASK (EFLAGS_MASK)
    ) u_cmp (
        .step     (s_step),
        .prev     (step_q),
        .mismatch (mm)
    );

    // Only read in RUN, so it never needs clearing
    always_ff @(posedge clk) begin
        if (accept) step_q <= s_step;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state         <= ST_IDLE;
            count         <= '0;
            fail_code     <= FC_NONE;
            fail_index    <= '0;
            mismatch_mask <= '0;
        end else if (accept) begin
            if (!at_max) count <= count + 1'b1;
            // Overflow outranks a mismatch; a failure outranks s_last
            if (at_max) begin
                state         <= ST_FAIL;
                fail_code     <= FC_OVERFLOW;
                fail_index    <= '1;
                mismatch_mask <= '0;
            end else if (state == ST_RUN && |mm) begin
                state         <= ST_FAIL;
                fail_code     <= FC_MISMATCH;
                fail_index    <= count;
                mismatch_mask <= mm;
            end else if (s_last) begin
                state <= ST_DONE;
            end else begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_trace_chain_checker.sv
// Randomised trace streams against a behavioural chain model; a 32-bit and a
// 3-bit counter instance share the same stimulus.
module tb_trace_chain_checker;

    logic         clk = 1'b0;
    logic         rst, clear, s_valid, s_last;
    logic [559:0] s_step;

    logic         ready0, done0, ok0, ready1, done1, ok1;
    logic [1:0]   code0, code1;
    logic [31:0]  idx0, cnt0;
    logic [2:0]   idx1, cnt1;
    logic [9:0]   mask0, mask1;

    always #5 clk = ~clk;

    trace_chain_checker u_dut (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(ready0),
        .s_step(s_step), .s_last(s_last), .done(done0), .ok(ok0), .fail_code(code0),
        .fail_index(idx0), .mismatch_mask(mask0), .step_count(cnt0)
    );

    trace_chain_checker #(.CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid), .s_ready(ready1),
        .s_step(s_step), .s_last(s_last), .done(done1), .ok(ok1), .fail_code(code1),
        .fail_index(idx1), .mismatch_mask(mask1), .step_count(cnt1)
    );

    logic        rdy_d [2];
    logic        done_d[2];
    logic        ok_d  [2];
    logic [1:0]  code_d[2];
    logic [31:0] idx_d [2];
    logic [9:0]  mask_d[2];
    logic [31:0] cnt_d [2];
    assign rdy_d[0]  = ready0;  assign rdy_d[1]  = ready1;
    assign done_d[0] = done0;   assign done_d[1] = done1;
    assign ok_d[0]   = ok0;     assign ok_d[1]   = ok1;
    assign code_d[0] = code0;   assign code_d[1] = code1;
    assign idx_d[0]  = idx0;    assign idx_d[1]  = {29'd0, idx1};
    assign mask_d[0] = mask0;   assign mask_d[1] = mask1;
    assign cnt_d[0]  = cnt0;    assign cnt_d[1]  = {29'd0, cnt1};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference ISA model ----------------
    function automatic int slot_of(input logic [2:0] enc);
        // eax ecx edx ebx esp ebp esi edi -> eax ebx ecx edx esi edi esp ebp
        case (enc)
            3'd0: return 0; 3'd1: return 2; 3'd2: return 3; 3'd3: return 1;
            3'd4: return 6; 3'd5: return 7; 3'd6: return 4; default: return 5;
        endcase
    endfunction

    function automatic logic [319:0] ref_exec(input logic [559:0] st);
        logic [31:0] R[10];
        logic [31:0] a, r, f, t;
        logic [7:0]  op;
        logic [319:0] out;
        int k, len;
        for (int i = 0; i < 10; i++) R[i] = st[i*32 +: 32];
        op  = st[320 +: 8];
        k   = slot_of(op[2:0]);
        len = 1;
        if (op >= 8'h40 && op <= 8'h4F) begin
            a = R[k];
            r = (op < 8'h48) ? a + 32'd1 : a - 32'd1;
            R[k] = r;
            f = R[9];
            t = a ^ r ^ 32'd1;
            f[11] = (op < 8'h48) ? (!a[31] && r[31]) : (a[31] && !r[31]);
            f[7]  = r[31];
            f[6]  = (r == 32'd0);
            f[4]  = t[4];
            f[2]  = ($countones(r[7:0]) % 2 == 0);
            R[9]  = f;
        end else if (op >= 8'hB8 && op <= 8'hBF) begin
            R[k] = st[328 +: 32];
            len  = 5;
        end
        R[8] = R[8] + len;
        for (int i = 0; i < 10; i++) out[i*32 +: 32] = R[i];
        return out;
    endfunction

    function automatic logic [9:0] model_mask(input logic [559:0] prev, input logic [559:0] cur);
        logic [319:0] p;
        logic [9:0]   m;
        p = ref_exec(prev);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) m[i] = ((p[i*32 +: 32] ^ cur[i*32 +: 32]) & 32'h0000_08D5) != 0;
            else        m[i] = p[i*32 +: 32] != cur[i*32 +: 32];
        end
        return m;
    endfunction

    // ---------------- chain model: 0 idle, 1 run, 2 done, 3 fail ----------------
    int           m_phase[2] = '{0, 0};
    longint       m_cnt  [2] = '{0, 0};
    longint       m_idx  [2] = '{0, 0};
    int           m_code [2] = '{0, 0};
    logic [9:0]   m_mask [2] = '{10'd0, 10'd0};
    logic [559:0] m_prev [2];
    bit           m_acc  [2] = '{0, 0};
    longint       m_max  [2] = '{64'hFFFF_FFFF, 64'd7};

    task automatic model_step();
        logic [9:0] mm;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            if (rst || clear) begin
                m_phase[i] = 0; m_cnt[i] = 0; m_idx[i] = 0; m_code[i] = 0; m_mask[i] = '0;
            end else if (s_valid && m_phase[i] <= 1) begin
                m_acc[i] = 1;
                mm = (m_phase[i] == 1) ? model_mask(m_prev[i], s_step) : 10'd0;
                if (m_cnt[i] == m_max[i]) begin
                    m_phase[i] = 3; m_code[i] = 2; m_idx[i] = m_max[i]; m_mask[i] = '0;
                end else begin
                    if (mm != 0) begin
                        m_phase[i] = 3; m_code[i] = 1; m_idx[i] = m_cnt[i]; m_mask[i] = mm;
                    end else begin
                        m_phase[i] = s_last ? 2 : 1;
                    end
                    m_cnt[i]++;
                end
                m_prev[i] = s_step;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.s_ready", i), rdy_d[i], (!clear && m_phase[i] <= 1));
                chk($sformatf("u%0d.done", i), done_d[i], (m_phase[i] >= 2));
                chk($sformatf("u%0d.ok", i), ok_d[i], (m_phase[i] == 2));
                chk($sformatf("u%0d.fail_code", i), code_d[i], m_code[i]);
                chk($sformatf("u%0d.fail_index", i), idx_d[i], m_idx[i]);
                chk($sformatf("u%0d.mismatch_mask", i), mask_d[i], m_mask[i]);
                chk($sformatf("u%0d.step_count", i), cnt_d[i], m_cnt[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; s_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_clear(input bit with_valid);
        clear = 1'b1; s_valid = with_valid;
        tick();
        clear = 1'b0; s_valid = 1'b0;
    endtask

    function automatic logic [319:0] rand_regs();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 5))
                0: r[i*32 +: 32] = 32'h0;
                1: r[i*32 +: 32] = 32'h7FFF_FFFF;
                2: r[i*32 +: 32] = 32'h8000_0000;
                3: r[i*32 +: 32] = 32'hFFFF_FFFF;
                4: r[i*32 +: 32] = 32'h0000_000F;
                default: r[i*32 +: 32] = $urandom;
            endcase
        end
        return r;
    endfunction

    function automatic logic [239:0] rand_insn();
        logic [239:0] x;
        logic [7:0]   g;
        for (int j = 0; j < 30; j++) x[j*8 +: 8] = 8'($urandom);
        g = 8'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0: x[7:0] = 8'h90;
            1: x[7:0] = 8'h40 | g;
            2: x[7:0] = 8'h48 | g;
            default: x[7:0] = 8'hB8 | g;
        endcase
        return x;
    endfunction

    // Builds an n-step trace chained by the reference model, with optional corruption
    task automatic trace(input int n, input int bad_k, input int bad_reg, input logic [31:0] bad_xor,
                         input bit end_last, input int vprob, input bit simple);
        logic [559:0] st;
        logic [319:0] regs;
        logic [239:0] insn;
        bit got;
        st = '0;
        for (int k = 0; k < n; k++) begin
            regs = (k == 0) ? rand_regs() : ref_exec(st);
            if (k == bad_k) regs[bad_reg*32 +: 32] = regs[bad_reg*32 +: 32] ^ bad_xor;
            insn = rand_insn();
            if (simple) insn[7:0] = (k % 2 == 1) ? 8'h40 : 8'h90;
            st = {insn, regs};
            s_step = st;
            s_last = end_last && (k == n - 1);
            got = 0;
            if (m_phase[0] >= 2) begin
                s_valid = 1'b1;
                tick();
                got = 1;
            end
            for (int w = 0; w < 64 && !got; w++) begin
                s_valid = ($urandom_range(0, 99) < vprob);
                tick();
                got = m_acc[0];
            end
            if (!got) chk("accept_bound", 0, 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        logic [559:0] pin;
        logic [319:0] pr;
        int c0;
        rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_step = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_done", done0, 0);
        chk("reset_step_count", cnt0, 0);
        chk("reset_fail_code", code0, 0);

        // Hand-computed single-step results pinning the reference model
        pin = '0; pin[31:0] = 32'h7FFF_FFFF; pin[8*32 +: 32] = 32'h1000; pin[320 +: 8] = 8'h40;
        pr = ref_exec(pin);
        chk("pin_inc_eax", pr[31:0], 32'h8000_0000);
        chk("pin_inc_flags", pr[288 +: 32], 32'h894);
        chk("pin_inc_eip", pr[256 +: 32], 32'h1001);
        pin[31:0] = 32'h8000_0000; pin[320 +: 8] = 8'h48;
        pr = ref_exec(pin);
        chk("pin_dec_flags", pr[288 +: 32], 32'h814);
        pin[320 +: 40] = 40'h12_3456_78BB;
        pr = ref_exec(pin);
        chk("pin_mov_ebx", pr[63:32], 32'h1234_5678);
        chk("pin_mov_eip", pr[256 +: 32], 32'h1005);

        trace(1, -1, 0, 0, 1, 100, 1);
        chk("single_done", done0, 1);
        chk("single_ok", ok0, 1);
        chk("single_count", cnt0, 1);
        chk("single_code", code0, 0);
        do_clear(0);

        c0 = cyc;
        trace(4, -1, 0, 0, 1, 100, 1);
        chk("chain4_cycles", cyc - c0, 4);
        chk("chain4_ok", ok0, 1);
        chk("chain4_count", cnt0, 4);
        do_clear(0);

        trace(6, 2, 0, 32'h1, 1, 100, 1);
        chk("eax_code", code0, 1);
        chk("eax_index", idx0, 2);
        chk("eax_mask", mask0, 10'b00_0000_0001);
        chk("eax_ready", ready0, 0);
        chk("eax_count", cnt0, 3);
        do_clear(1);
        chk("clear_done", done0, 0);
        chk("clear_code", code0, 0);
        chk("clear_index", idx0, 0);
        chk("clear_mask", mask0, 0);
        chk("clear_count", cnt0, 0);

        trace(3, 1, 9, 32'h200, 1, 100, 1);
        chk("if_bit_ok", ok0, 1);
        do_clear(0);
        trace(3, 1, 9, 32'h40, 1, 100, 1);
        chk("zf_mask", mask0, 10'h200);
        chk("zf_index", idx0, 1);
        do_clear(0);

        trace(9, -1, 0, 0, 0, 100, 1);
        chk("ovf_code", code1, 2);
        chk("ovf_index", idx1, 3'b111);
        chk("ovf_count", cnt1, 3'b111);
        chk("wide_count", cnt0, 9);
        chk("wide_done", done0, 0);
        do_clear(1);

        repeat (40) begin
            int n, bk;
            n  = $urandom_range(1, 12);
            bk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n)) : -1;
            trace(n, bk, $urandom_range(0, 9), 32'h1 << $urandom_range(0, 31),
                  $urandom_range(0, 3) != 0, $urandom_range(40, 100), 0);
            tick();
            if ($urandom_range(0, 3) == 0) do_reset();
            else do_clear($urandom_range(0, 1) == 1);
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
